// File: rtl/ram_bist_master_if.sv
// Request/response bus between the BIST master and the 8-bit x 16 single-port RAM.
// The master drives the request fields; the RAM returns read data and ready.
interface ram_bist_master_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) ();
    logic              Wr_Rd;
    logic              valid;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] WDATA;
    logic [DATA_W-1:0] RDATA;
    logic              ready;

    modport master (output Wr_Rd, valid, ADDR, WDATA, input RDATA, ready);
    modport slave  (input Wr_Rd, valid, ADDR, WDATA, output RDATA, ready);
endinterface

// File: rtl/ram_bist_master.sv
// Four-phase write/read-compare self-test master for a single-port RAM:
// write P(a), read/compare, write ~P(a), read/compare, with a ready-stall timeout.
module ram_bist_master #(
    parameter int                DATA_W  = 8,
    parameter int                ADDR_W  = 4,
    parameter logic [DATA_W-1:0] SEED    = DATA_W'(8'hA5),
    parameter int                TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [ADDR_W+1:0]    err_count,
    output logic [ADDR_W-1:0]    first_fail_addr,
    output logic [DATA_W-1:0]    first_fail_data,
    ram_bist_master_if.master    bus
);

    typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, DONE} state_t;

    // Stall counter only needs to hold TIMEOUT-1; reaching the limit aborts instead.
    localparam int                TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]     TLIM = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [ADDR_W-1:0] LAST = '1;

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return DATA_W'(a) ^ SEED;
    endfunction

    state_t            state;
    logic [TW-1:0]     tcnt;
    logic              req_wr;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    assign bus.Wr_Rd = req_wr;
    assign bus.valid = req_valid;
    assign bus.ADDR  = req_addr;
    assign bus.WDATA = req_wdata;

    logic              hs;
    logic              mism;
    logic              stall_hit;
    logic [DATA_W-1:0] expect_data;
    logic [ADDR_W-1:0] nxt_addr;
    logic [DATA_W-1:0] nxt_wdata;
    state_t            nxt_state;

    always_comb begin
        hs          = req_valid && bus.ready;
        expect_data = (state == R1) ? ~pat(req_addr) : pat(req_addr);
        mism        = ((state == R0) || (state == R1)) && (bus.RDATA != expect_data);
        stall_hit   = (TIMEOUT != 0) && req_valid && !bus.ready && (tcnt == TLIM);
        nxt_addr    = (req_addr == LAST) ? '0 : req_addr + ADDR_W'(1);
        nxt_state   = state;
        if (req_addr == LAST) begin
            case (state)
                W0:      nxt_state = R0;
                R0:      nxt_state = W1;
                W1:      nxt_state = R1;
                R1:      nxt_state = DONE;
                default: nxt_state = state;
            endcase
        end
        case (nxt_state)
            W0:      nxt_wdata = pat(nxt_addr);
            W1:      nxt_wdata = ~pat(nxt_addr);
            default: nxt_wdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            tcnt            <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            timeout         <= 1'b0;
            err_count       <= '0;
            first_fail_addr <= '0;
            first_fail_data <= '0;
            req_wr          <= 1'b0;
            req_valid       <= 1'b0;
            req_addr        <= '0;
            req_wdata       <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state           <= W0;
                        tcnt            <= '0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        timeout         <= 1'b0;
                        err_count       <= '0;
                        first_fail_addr <= '0;
                        first_fail_data <= '0;
                        req_wr          <= 1'b1;
                        req_valid       <= 1'b1;
                        req_addr        <= '0;
                        req_wdata       <= pat('0);
                    end
                end
                default: begin
                    if (hs) begin
                        tcnt <= '0;
                        if (mism) begin
                            err_count <= err_count + (ADDR_W+2)'(1);
                            if (err_count == '0) begin
                                first_fail_addr <= req_addr;
                                first_fail_data <= bus.RDATA;
                            end
                        end
                        if (nxt_state == DONE) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            pass      <= (err_count == '0) && !mism;
                            req_valid <= 1'b0;
                            req_wr    <= 1'b0;
                            req_addr  <= '0;
                            req_wdata <= '0;
                        end else begin
                            // Next request goes out right away so valid never drops.
                            state     <= nxt_state;
                            req_addr  <= nxt_addr;
                            req_wr    <= (nxt_state == W0) || (nxt_state == W1);
                            req_wdata <= nxt_wdata;
                        end
                    end else if (stall_hit) begin
                        // Request fields stay frozen on the stalled access for debug.
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        timeout   <= 1'b1;
                        pass      <= 1'b0;
                        req_valid <= 1'b0;
                    end else if (TIMEOUT != 0) begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
            endcase
        end
    end

endmodule
